// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - function codes and FSM state type for the sequential multiply/divide unit
package muldiv_pkg;

  localparam int MULT  = 24;
  localparam int MULTU = 25;
  localparam int DIV   = 26;
  localparam int DIVU  = 27;
  localparam int OUT   = 63;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate, used for operand abs and result fix-up
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit, one shift-add or restoring-subtract step per clock
module seq_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [FUNCT_W-1:0]   Signal,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state;
  state_t               next_state;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic [CW-1:0]        counter;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz;

  logic                 div_op;
  logic                 signed_op;
  logic                 valid_op;
  logic                 accept;
  logic                 zero_div;
  logic                 last_step;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH+1:0]     add_a;
  logic [WIDTH+1:0]     add_b;
  logic [WIDTH+1:0]     sum;
  logic                 ge;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed;
  logic [WIDTH-1:0]     rem_fixed;
  logic [2*WIDTH-1:0]   result;

  assign div_op    = (Signal == FUNCT_W'(DIV)) || (Signal == FUNCT_W'(DIVU));
  assign signed_op = (Signal == FUNCT_W'(MULT)) || (Signal == FUNCT_W'(DIV));
  assign valid_op  = div_op || (Signal == FUNCT_W'(MULT)) || (Signal == FUNCT_W'(MULTU));
  assign accept    = start && valid_op && ((state == IDLE) || (state == DONE));
  assign zero_div  = div_op && (dataB == '0);
  assign last_step = (counter == CW'(WIDTH - 1));

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.value(dataA), .neg(signed_op & dataA[WIDTH-1]), .result(abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.value(dataB), .neg(signed_op & dataB[WIDTH-1]), .result(abs_b));

  // One shared adder: divide subtracts via ~opb + 1, the carry-out is the rem>=divisor test.
  assign add_a = is_div ? {1'b0, acc[2*WIDTH-1:WIDTH-1]} : {2'b00, acc[2*WIDTH-1:WIDTH]};
  assign add_b = is_div ? {1'b0, ~{1'b0, opb}} : {2'b00, (acc[0] ? opb : {WIDTH{1'b0}})};
  assign sum   = add_a + add_b + (WIDTH+2)'(is_div);
  assign ge    = sum[WIDTH+1];

  always_comb begin
    acc_step = {sum[WIDTH:0], acc[WIDTH-1:1]};
    if (is_div) begin
      if (ge) acc_step = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else    acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value(acc), .neg(neg_q), .result(prod_fixed));
  muldiv_sign_fix #(.W(WIDTH))   u_fix_quo  (.value(acc[WIDTH-1:0]), .neg(neg_q), .result(quo_fixed));
  muldiv_sign_fix #(.W(WIDTH))   u_fix_rem  (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .result(rem_fixed));

  assign result = is_div ? {rem_fixed, quo_fixed} : prod_fixed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (accept)              next_state = zero_div ? DONE : RUN;
        else if (state == DONE)  next_state = IDLE;
      end
      RUN:     if (last_step) next_state = FIX;
      FIX:     next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the state, so they trail it by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      opb         <= '0;
      counter     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      dataOut     <= '0;
    end else begin
      busy <= (state == RUN) || (state == FIX);
      done <= (state == DONE);
      if (state == RUN) begin
        acc     <= acc_step;
        counter <= last_step ? '0 : counter + CW'(1);
      end
      if (state == FIX) dataOut <= result;
      if (accept) begin
        is_div      <= div_op;
        neg_q       <= signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        neg_r       <= signed_op & dataA[WIDTH-1];
        acc         <= div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        opb         <= div_op ? abs_b : abs_a;
        counter     <= '0;
        dz          <= zero_div;
        div_by_zero <= 1'b0;
        if (zero_div) dataOut <= {dataA, {WIDTH{1'b1}}};
      end
      if (state == DONE) div_by_zero <= dz;
    end
  end

endmodule
